// File: rtl/branch_sequencer.sv
// branch_sequencer: sequences a conditional branch against the condition
// flip-flop and owns the program counter (increment, load, branch).
module branch_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 19,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ir,
  input  logic             condition,
  input  logic             pc_inc,
  input  logic             pc_write,
  input  logic [WIDTH-1:0] pc_in,
  output logic [3:0]       c2,
  output logic             con_enable,
  output logic             ra_out,
  output logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             done,
  output logic             taken
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_RESOLVE,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       c2_q, c2_d;
  logic [WIDTH-1:0] off_q, off_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             taken_q, taken_d;

  logic unused_ir;
  assign unused_ir = ^ir[WIDTH-1:23];

  // state register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state: one cycle per non-idle state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_EVAL;
      S_EVAL:    state_d = S_RESOLVE;
      S_RESOLVE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state only
  always_comb begin
    con_enable = 1'b0;
    ra_out     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE:    busy = 1'b0;
      S_EVAL: begin
        con_enable = 1'b1;
        ra_out     = 1'b1;
      end
      S_RESOLVE: ;
      S_DONE:    done = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // datapath next values: capture, PC update, branch resolve
  always_comb begin
    c2_d    = c2_q;
    off_d   = off_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        c2_d  = ir[22:19];
        off_d = {{(WIDTH-IMM_W){ir[IMM_W-1]}},
                 ir[IMM_W-1:0]};
      end
      if (pc_write)    pc_d = pc_in;
      else if (pc_inc) pc_d = pc_q + ONE;
    end else if (state_q == S_RESOLVE) begin
      taken_d = condition;
      if (condition) pc_d = pc_q + off_q;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      c2_q    <= '0;
      off_q   <= '0;
      pc_q    <= PC_RESET;
      taken_q <= 1'b0;
    end else begin
      c2_q    <= c2_d;
      off_q   <= off_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

  assign c2    = c2_q;
  assign pc    = pc_q;
  assign taken = taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed vectors for branch_sequencer.
// Inputs change and outputs are sampled at the falling edge.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        start;
  logic [31:0] ir;
  logic        condition;
  logic        pc_inc;
  logic        pc_write;
  logic [31:0] pc_in;
  logic [3:0]  c2;
  logic        con_enable;
  logic        ra_out;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic        taken;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_sequencer dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .start      (start),
    .ir         (ir),
    .condition  (condition),
    .pc_inc     (pc_inc),
    .pc_write   (pc_write),
    .pc_in      (pc_in),
    .c2         (c2),
    .con_enable (con_enable),
    .ra_out     (ra_out),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .taken      (taken)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_write = 1'b1;
    pc_in    = v;
    @(negedge clk);
    pc_write = 1'b0;
    check("set_pc", pc, v);
  endtask

  // Caller is at a falling edge in IDLE.
  task automatic branch(input string tag,
                        input logic [31:0] irv,
                        input logic cond,
                        input logic inc,
                        input logic noise,
                        input logic [31:0] pc_mid,
                        input logic [31:0] exp_pc);
    start  = 1'b1;
    ir     = irv;
    pc_inc = inc;
    @(negedge clk);
    start  = 1'b0;
    pc_inc = 1'b0;
    check({tag, ".eval.cen"}, 32'(con_enable), 32'd1);
    check({tag, ".eval.ra"}, 32'(ra_out), 32'd1);
    check({tag, ".eval.busy"}, 32'(busy), 32'd1);
    check({tag, ".eval.done"}, 32'(done), 32'd0);
    check({tag, ".eval.c2"}, 32'(c2), 32'(irv[22:19]));
    check({tag, ".eval.pc"}, pc, pc_mid);
    condition = cond;
    if (noise) begin
      start    = 1'b1;
      pc_inc   = 1'b1;
      pc_write = 1'b1;
      pc_in    = 32'hDEAD_0000;
      ir       = 32'h0038_0000;
    end
    @(negedge clk);
    check({tag, ".res.cen"}, 32'(con_enable), 32'd0);
    check({tag, ".res.ra"}, 32'(ra_out), 32'd0);
    check({tag, ".res.done"}, 32'(done), 32'd0);
    check({tag, ".res.c2"}, 32'(c2), 32'(irv[22:19]));
    check({tag, ".res.pc"}, pc, pc_mid);
    if (noise) begin
      start    = 1'b0;
      pc_inc   = 1'b0;
      pc_write = 1'b0;
    end
    @(negedge clk);
    condition = 1'b0;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".pc"}, pc, exp_pc);
    check({tag, ".taken"}, 32'(taken), 32'(cond));
    @(negedge clk);
    check({tag, ".idle.done"}, 32'(done), 32'd0);
    check({tag, ".idle.busy"}, 32'(busy), 32'd0);
    check({tag, ".idle.c2"}, 32'(c2), 32'(irv[22:19]));
    @(negedge clk);
    check({tag, ".after.busy"}, 32'(busy), 32'd0);
    check({tag, ".after.pc"}, pc, exp_pc);
  endtask

  initial begin
    clear_n   = 1'b0;
    start     = 1'b0;
    ir        = '0;
    condition = 1'b0;
    pc_inc    = 1'b0;
    pc_write  = 1'b0;
    pc_in     = '0;
    #1;
    check("rst.pc", pc, 32'h0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.c2", 32'(c2), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);

    // asynchronous reset mid-cycle
    set_pc(32'h55);
    #2 clear_n = 1'b0;
    #1;
    check("arst.pc", pc, 32'h0);
    check("arst.done", 32'(done), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);

    set_pc(32'h10);
    branch("brzr", 32'h0000_0005, 1'b1, 1'b0, 1'b0,
           32'h10, 32'h15);
    branch("ntk", 32'h000F_FFFC, 1'b0, 1'b0, 1'b0,
           32'h15, 32'h15);
    set_pc(32'h20);
    branch("neg", 32'h0007_FFFC, 1'b1, 1'b0, 1'b0,
           32'h20, 32'h1C);

    // pc_write wins over pc_inc
    pc_write = 1'b1;
    pc_inc   = 1'b1;
    pc_in    = 32'h100;
    @(negedge clk);
    pc_write = 1'b0;
    check("prio.pc", pc, 32'h100);
    @(negedge clk);
    pc_inc = 1'b0;
    check("inc.pc", pc, 32'h101);

    set_pc(32'h40);
    branch("incbr", 32'hFF78_0002, 1'b1, 1'b1, 1'b0,
           32'h41, 32'h43);
    branch("busy", 32'h0000_0010, 1'b1, 1'b0, 1'b1,
           32'h43, 32'h53);

    set_pc(32'hFFFF_FFFE);
    branch("wrap", 32'h0000_0003, 1'b1, 1'b0, 1'b0,
           32'hFFFF_FFFE, 32'h1);
    set_pc(32'hFFFF_FFFF);
    pc_inc = 1'b1;
    @(negedge clk);
    pc_inc = 1'b0;
    check("incwrap.pc", pc, 32'h0);

    // abort during RESOLVE
    set_pc(32'h200);
    start = 1'b1;
    ir    = 32'h0008_0004;
    @(negedge clk);
    start     = 1'b0;
    condition = 1'b1;
    @(negedge clk);
    check("abort.busy0", 32'(busy), 32'd1);
    clear_n = 1'b0;
    #1;
    check("abort.pc", pc, 32'h0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.taken", 32'(taken), 32'd0);
    check("abort.c2", 32'(c2), 32'd0);
    @(negedge clk);
    check("abort.done", 32'(done), 32'd0);
    check("abort.pc2", pc, 32'h0);
    clear_n   = 1'b1;
    condition = 1'b0;
    @(negedge clk);
    check("abort.done2", 32'(done), 32'd0);
    check("abort.idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Consumer side of the branch-condition flip-flop. It sequences a conditional-branch instruction.
- Captures the instruction, drives c2 and con_enable to the condition flip-flop, and requests Ra onto the bus.
- Samples the registered condition and updates its PC register with PC + sign-extended offset when the branch is taken.
- Sits in the control path beside the control unit; also owns normal PC increment and absolute PC load.

Parameters:
WIDTH, 32, datapath/PC width
IMM_W, 19, branch offset field width (ir[IMM_W-1:0])
PC_RESET, 0, PC value after reset

Ports:
clk  input  1  rising-edge clock
clear_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse from control unit: ir holds a branch instruction
ir  input  WIDTH  instruction; c2 field ir[22:19], offset ir[IMM_W-1:0]
condition  input  1  registered result from condition flip-flop
pc_inc  input  1  fetch increment request (PC <= PC+1)
pc_write  input  1  absolute PC load request
pc_in  input  WIDTH  absolute PC load value
c2  output  4  condition select to condition flip-flop
con_enable  output  1  condition flip-flop load enable
ra_out  output  1  request register Ra onto bus
pc  output  WIDTH  current PC
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse, branch resolved
taken  output  1  result of last branch, held until next resolve

Behaviour:
- Reset (clear_n low, asynchronous, any state): state=IDLE, pc=PC_RESET, c2=0, taken=0. con_enable, ra_out, busy and done are 0. Release is sampled synchronously at the next clk edge.
- States: IDLE -> EVAL -> RESOLVE -> DONE -> IDLE. Each non-IDLE state lasts exactly one cycle.
- con_enable, ra_out, busy and done decode only from the state register (Moore outputs); no combinational path from inputs to them.
- IDLE:
  - start=1: capture c2_q=ir[22:19] and off_q=sign-extend(ir[IMM_W-1:0]) to WIDTH; go to EVAL.
  - pc_write=1 loads pc=pc_in; else pc_inc=1 gives pc=pc+1. pc_write has priority over pc_inc.
  - start with pc_inc in the same cycle: the increment is applied and the branch is captured. The offset is relative to the incremented PC.
- EVAL: ra_out=1, con_enable=1, c2=c2_q. The condition flip-flop loads at the end of this cycle.
- RESOLVE: condition is valid.
  - At the edge: taken<=condition; if condition=1, pc<=pc+off_q, else pc unchanged.
  - con_enable=0, ra_out=0.
- DONE: done=1 for one cycle, then IDLE.
- c2 output holds c2_q from the capture edge until the next capture (outside reset). It is stable before and during EVAL.
- Latency: start sampled at edge k; con_enable high in cycle k+1; pc updated at edge k+2; done high in cycle k+3.
- While busy: start, pc_inc and pc_write are ignored (not queued).
- Arithmetic: PC add/increment is modulo 2^WIDTH. pc=0xFFFFFFFF plus 1 gives 0; negative offsets wrap correctly.
- The offset field is 2's-complement. ir[IMM_W-1]=1 sign-extends with ones.
- c2[3:2] is passed through unmodified; the flip-flop decodes only c2[1:0].
- Reset asserted mid-sequence aborts with no PC update and no done pulse.

Test Plan:
- Reset: hold clear_n=0 mid-cycle -> pc=0, all flags 0 immediately, without waiting for clk.
- Taken brzr: pc=0x10, ir c2=0000, offset=0x00005, bus=0, condition returns 1 -> con_enable only in cycle k+1; pc=0x15 after edge k+2; done in k+3; taken=1.
- Not taken / negative offset:
  - condition=0, offset=0x7FFFC -> pc unchanged, taken=0.
  - condition=1, pc=0x20 -> pc=0x1C.
- Priority:
  - pc_write=1, pc_in=0x100 and pc_inc=1 together in IDLE -> pc=0x100.
  - start plus pc_inc with pc=0x40, offset 2, taken -> pc=0x43.
- Busy: pulse start, pc_inc and pc_write during EVAL/RESOLVE -> all ignored; exactly one done; pc reflects only the original branch.
- Wrap and abort:
  - pc=0xFFFFFFFE, offset 3, taken -> pc=0x00000001.
  - clear_n low during RESOLVE -> pc=PC_RESET, no done.
